// File: rtl/axi_lite_mem_arbiter_pkg.sv
// Shared types and constants for the SRAM AXI-lite arbiter: grant encodings,
// the arbiter state enum and the state-to-grant decode.
package axi_lite_mem_arbiter_pkg;

    localparam int NUM_ARB_MASTERS = 2;

    localparam logic [NUM_ARB_MASTERS-1:0] EMPTY_GRANT   = 2'b00;
    localparam logic [NUM_ARB_MASTERS-1:0] INSTMEM_GRANT = 2'b01;
    localparam logic [NUM_ARB_MASTERS-1:0] DATAMEM_GRANT = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        I_RD = 2'd1,
        D_RD = 2'd2,
        D_WR = 2'd3
    } arb_state_e;

    function automatic logic [NUM_ARB_MASTERS-1:0] grant_of(arb_state_e s);
        case (s)
            I_RD:       return INSTMEM_GRANT;
            D_RD, D_WR: return DATAMEM_GRANT;
            default:    return EMPTY_GRANT;
        endcase
    endfunction

endpackage

// File: rtl/axi_lite_mem_arbiter_if.sv
// Request/handshake and grant signals between the I/D masters, the SRAM slave
// and the arbiter. The arbiter connects through the slave modport.
interface axi_lite_mem_arbiter_if;
    import axi_lite_mem_arbiter_pkg::*;

    logic                       i_arvalid;
    logic                       d_arvalid;
    logic                       d_awvalid;
    logic                       d_wvalid;
    logic                       rvalid;
    logic                       i_rready;
    logic                       d_rready;
    logic                       bvalid;
    logic                       d_bready;
    logic [NUM_ARB_MASTERS-1:0] grant;
    logic                       busy;
    logic                       timeout;

    modport master (
        output i_arvalid, d_arvalid, d_awvalid, d_wvalid,
        output rvalid, i_rready, d_rready, bvalid, d_bready,
        input  grant, busy, timeout
    );

    modport slave (
        input  i_arvalid, d_arvalid, d_awvalid, d_wvalid,
        input  rvalid, i_rready, d_rready, bvalid, d_bready,
        output grant, busy, timeout
    );

endinterface

// File: rtl/axi_lite_mem_arbiter_arb_watchdog.sv
// Grant-hold watchdog: counts busy cycles and flags expiry on the last allowed
// cycle; the timeout pulse is suppressed when the transaction completes then.
module arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int TO_CNT_W       = 9
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic done,
    output logic expire,
    output logic timeout
);

    localparam logic [TO_CNT_W-1:0] LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [TO_CNT_W-1:0] cnt;

    assign expire = active && (cnt == LAST);

    // Cleared while idle so every grant starts counting from zero; holds at LAST.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= expire && !done;
            if (!active)
                cnt <= '0;
            else if (cnt != LAST)
                cnt <= cnt + TO_CNT_W'(1);
        end
    end

endmodule

// File: rtl/axi_lite_mem_arbiter.sv
// Two-master (I fetch / D load-store) arbiter for the SRAM AXI-lite slave.
// Define ARB_RR_EN for round-robin I/D arbitration; default is fixed D-over-I.
module axi_lite_mem_arbiter
    import axi_lite_mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int TO_CNT_W       = 9
) (
    input logic                  clk,
    input logic                  rst,
    axi_lite_mem_arbiter_if.slave bus
);

    arb_state_e state, nxt;
    logic       done, expire, d_req, wr_req, pick_d, in_txn;

    assign in_txn = (state != IDLE);
    assign d_req  = bus.d_arvalid || bus.d_awvalid;
    // A write opens on the address alone; wvalid never opens one by itself.
    assign wr_req = bus.d_awvalid || (bus.d_awvalid && bus.d_wvalid);

    always_comb begin
        done = 1'b0;
        case (state)
            I_RD:    done = bus.rvalid && bus.i_rready;
            D_RD:    done = bus.rvalid && bus.d_rready;
            D_WR:    done = bus.bvalid && bus.d_bready;
            default: done = 1'b0;
        endcase
    end

`ifdef ARB_RR_EN
    logic last_d;

    always_ff @(posedge clk) begin
        if (rst)
            last_d <= 1'b0;
        else if (state == IDLE && nxt != IDLE)
            last_d <= (nxt != I_RD);
    end

    assign pick_d = d_req && (!bus.i_arvalid || !last_d);
`else
    assign pick_d = d_req;
`endif

    always_comb begin
        nxt = state;
        case (state)
            IDLE: begin
                if (pick_d)
                    nxt = wr_req ? D_WR : D_RD;
                else if (bus.i_arvalid)
                    nxt = I_RD;
            end
            default: if (done || expire) nxt = IDLE;
        endcase
    end

    // Every release passes through IDLE, giving the one-cycle empty-grant bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bus.grant <= EMPTY_GRANT;
            bus.busy  <= 1'b0;
        end else begin
            state     <= nxt;
            bus.grant <= grant_of(nxt);
            bus.busy  <= (nxt != IDLE);
        end
    end

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_wd
            arb_watchdog #(
                .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
                .TO_CNT_W      (TO_CNT_W)
            ) u_wd (
                .clk    (clk),
                .rst    (rst),
                .active (in_txn),
                .done   (done),
                .expire (expire),
                .timeout(bus.timeout)
            );
        end else begin : g_no_wd
            assign expire      = 1'b0;
            assign bus.timeout = 1'b0;
        end
    endgenerate

endmodule
